cordic_sincos: RTL and testbench



---
 rtl/cordic_sincos_if.sv | 12 +
 rtl/cordic_sincos.sv | 161 ++++++++++++++++
 tb/tb_cordic_sincos.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cordic_sincos_if.sv
// Request/response bundle for the rotation-mode CORDIC sin/cos engine.
interface cordic_sincos_if;
    logic        start;
    logic [31:0] angle;    // signed Q8.24 degrees
    logic        busy;
    logic        done;
    logic [31:0] cos_out;  // signed Q2.30
    logic [31:0] sin_out;  // signed Q2.30

    modport master (output start, angle, input  busy, done, cos_out, sin_out);
    modport slave  (input  start, angle, output busy, done, cos_out, sin_out);
endinterface

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, angle in
// Q8.24 degrees, cos/sin out in Q2.30. Shares the Q8.32 degree arctan table
// with the vectoring-mode arctan block so the two chain without rescaling.
// ITER is meant to lie in 8..38 (the table has 38 entries).
module cordic_sincos #(
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    cordic_sincos_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [5:0]         LAST  = 6'(ITER);
    localparam logic signed [39:0] KINV  = 40'sh00_26DD_3B6A;  // 1/K, Q10.30
    localparam logic signed [39:0] DEG90 = 40'sh5A_0000_0000;  // 90 deg, Q8.32
    localparam logic signed [31:0] ANG90 = 32'sh5A00_0000;     // 90 deg, Q8.24

    // arctan(2^-i) in degrees, Q8.32
    function automatic logic signed [39:0] atan_lut(input logic [5:0] idx);
        case (idx)
            6'd0:  atan_lut = 40'h2D_0000_0000;
            6'd1:  atan_lut = 40'h1A_90A7_31A6;
            6'd2:  atan_lut = 40'h0E_0947_407D;
            6'd3:  atan_lut = 40'h07_2001_124A;
            6'd4:  atan_lut = 40'h03_938A_A64C;
            6'd5:  atan_lut = 40'h01_CA37_94E5;
            6'd6:  atan_lut = 40'h00_E52A_1AB2;
            6'd7:  atan_lut = 40'h00_7296_D7A1;
            6'd8:  atan_lut = 40'h00_394B_A51C;
            6'd9:  atan_lut = 40'h00_1CA5_D9B7;
            6'd10: atan_lut = 40'h00_0E52_EDC1;
            6'd11: atan_lut = 40'h00_0729_76FD;
            6'd12: atan_lut = 40'h00_0394_BB82;
            6'd13: atan_lut = 40'h00_01CA_5DC2;
            6'd14: atan_lut = 40'h00_00E5_2EE1;
            6'd15: atan_lut = 40'h00_0072_9770;
            6'd16: atan_lut = 40'h00_0039_4BB8;
            6'd17: atan_lut = 40'h00_001C_A5DC;
            6'd18: atan_lut = 40'h00_000E_52EE;
            6'd19: atan_lut = 40'h00_0007_2977;
            6'd20: atan_lut = 40'h00_0003_94BC;
            6'd21: atan_lut = 40'h00_0001_CA5E;
            6'd22: atan_lut = 40'h00_0000_E52F;
            6'd23: atan_lut = 40'h00_0000_7297;
            6'd24: atan_lut = 40'h00_0000_394C;
            6'd25: atan_lut = 40'h00_0000_1CA6;
            6'd26: atan_lut = 40'h00_0000_0E53;
            6'd27: atan_lut = 40'h00_0000_0729;
            6'd28: atan_lut = 40'h00_0000_0395;
            6'd29: atan_lut = 40'h00_0000_01CA;
            6'd30: atan_lut = 40'h00_0000_00E5;
            6'd31: atan_lut = 40'h00_0000_0073;
            6'd32: atan_lut = 40'h00_0000_0039;
            6'd33: atan_lut = 40'h00_0000_001D;
            6'd34: atan_lut = 40'h00_0000_000E;
            6'd35: atan_lut = 40'h00_0000_0007;
            6'd36: atan_lut = 40'h00_0000_0004;
            6'd37: atan_lut = 40'h00_0000_0002;
            default: atan_lut = '0;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic signed [39:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [31:0]        cos_q, cos_d, sin_q, sin_d;

    logic signed [39:0] ang_ext, ld_x, ld_y, ld_z, x_sh, y_sh, at_i;

    assign ang_ext = {bus.angle, 8'h00};
    assign x_sh    = x_q >>> cnt_q;
    assign y_sh    = y_q >>> cnt_q;
    assign at_i    = atan_lut(cnt_q);

    // Quadrant pre-rotation: start from +/-90 deg when |angle| exceeds the
    // CORDIC convergence range (~99.9 deg), leaving |z| <= 90 deg.
    always_comb begin
        ld_x = KINV;
        ld_y = '0;
        ld_z = ang_ext;
        if ($signed(bus.angle) > ANG90) begin
            ld_x = '0;
            ld_y = KINV;
            ld_z = ang_ext - DEG90;
        end else if ($signed(bus.angle) < -ANG90) begin
            ld_x = '0;
            ld_y = -KINV;
            ld_z = ang_ext + DEG90;
        end
    end

    // Next state: accept/load, micro-rotate, latch result.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cos_d   = cos_q;
        sin_d   = sin_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    x_d     = ld_x;
                    y_d     = ld_y;
                    z_d     = ld_z;
                end
            end
            RUN: begin
                if (cnt_q == LAST) begin
                    cos_d   = x_q[31:0];
                    sin_d   = y_q[31:0];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    // z == 0 rotates in the positive direction
                    if (!z_q[39]) begin
                        x_d = x_q - y_sh;
                        y_d = y_q + x_sh;
                        z_d = z_q - at_i;
                    end else begin
                        x_d = x_q + y_sh;
                        y_d = y_q - x_sh;
                        z_d = z_q + at_i;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cos_q   <= cos_d;
            sin_q   <= sin_d;
        end
    end

    assign bus.busy    = (state_q == RUN);
    assign bus.done    = (state_q == DONE);
    assign bus.cos_out = cos_q;
    assign bus.sin_out = sin_q;
endmodule

// File: tb/tb_cordic_sincos.sv
// Self-checking bench for cordic_sincos: directed corners, handshake cases,
// a 1-degree sweep and random angles against an ideal real-math sin/cos.
module tb_cordic_sincos;
    localparam int  LAT = 33;
    localparam int  TOL = 64;
    localparam real PI  = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    cordic_sincos_if bus();

    cordic_sincos #(.ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Ideal result: round(cos/sin(angle) * 2^30)
    function automatic longint model_trig(input logic [31:0] a, input bit want_sin);
        real r;
        r = real'($signed(a)) / 16777216.0 * PI / 180.0;
        return want_sin ? longint'($sin(r) * 1073741824.0) : longint'($cos(r) * 1073741824.0);
    endfunction

    // Angle recovered from a (cos, sin) pair, in Q8.24 degrees
    function automatic longint recover_angle(input logic [31:0] c, input logic [31:0] s);
        real d;
        d = $atan2(real'($signed(s)), real'($signed(c))) * 180.0 / PI;
        return longint'(d * 16777216.0);
    endfunction

    task automatic chk_eq(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input longint obs, input longint exp, input longint tol);
        longint diff;
        n_cmp++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        assert ((diff <= tol) === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_result(input string tag, input logic [31:0] a);
        chk_tol({tag, " cos"}, longint'($signed(bus.cos_out)), model_trig(a, 1'b0), TOL);
        chk_tol({tag, " sin"}, longint'($signed(bus.sin_out)), model_trig(a, 1'b1), TOL);
    endtask

    // Returns cycles from the current point until done is seen (bounded)
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    // Single transaction from IDLE, with a junk angle driven while busy
    task automatic run_op(input logic [31:0] a, input string tag, input bit rt);
        int cyc;
        bus.angle = a;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.angle = $urandom;
        chk_eq({tag, " busy"}, longint'(bus.busy), 1);
        wait_done(cyc);
        chk_eq({tag, " latency"}, cyc, LAT);
        chk_result(tag, a);
        if (rt)
            chk_tol({tag, " roundtrip"}, recover_angle(bus.cos_out, bus.sin_out),
                    longint'($signed(a)), 256);
        tick();
        chk_eq({tag, " done fall"}, longint'(bus.done), 0);
    endtask

    initial begin
        int cyc;
        int ndone;
        logic [31:0] a;
        logic [31:0] dir [9];
        logic [31:0] bb  [3];

        bus.start = 1'b0;
        bus.angle = '0;

        // reset
        rst_n = 1'b0;
        tick();
        tick();
        chk_eq("rst busy", longint'(bus.busy), 0);
        chk_eq("rst done", longint'(bus.done), 0);
        chk_eq("rst cos", longint'(bus.cos_out), 0);
        chk_eq("rst sin", longint'(bus.sin_out), 0);
        rst_n = 1'b1;
        tick();

        // directed angles: zero, 30, -45, 120, -128, +/-90, pre-rotation edges
        dir = '{32'h0000_0000, 32'h1E00_0000, 32'hD300_0000, 32'h7800_0000,
                32'h8000_0000, 32'h5A00_0000, 32'hA600_0000, 32'h5A00_0001,
                32'h7FFF_FFFF};
        for (int i = 0; i < 9; i++) run_op(dir[i], $sformatf("dir%0d", i), 1'b1);

        // start pulses and angle changes while running are ignored
        a = 32'h2D40_0000;
        bus.angle = a;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin
            bus.start = (cyc == 5 || cyc == 10 || cyc == 20);
            bus.angle = $urandom;
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        chk_eq("ignore latency", cyc, LAT);
        chk_result("ignore", a);
        tick();
        chk_eq("ignore idle", longint'(bus.busy), 0);

        // start held high: back-to-back results
        bb = '{32'h1E00_0000, 32'hC400_0000, 32'h6E80_0000};
        bus.angle = bb[0];
        bus.start = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            bus.angle = $urandom;
            wait_done(cyc);
            chk_eq($sformatf("b2b%0d period", k), cyc, LAT);
            chk_result($sformatf("b2b%0d", k), bb[k]);
            if (k < 2) bus.angle = bb[k+1];
            else       bus.start = 1'b0;
            tick();
            chk_eq($sformatf("b2b%0d done pulse", k), longint'(bus.done), 0);
            chk_eq($sformatf("b2b%0d busy", k), longint'(bus.busy), (k < 2) ? 1 : 0);
        end

        // reset in the middle of a computation
        bus.angle = 32'hE000_0000;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_eq("midrst busy", longint'(bus.busy), 0);
        chk_eq("midrst done", longint'(bus.done), 0);
        chk_eq("midrst cos", longint'(bus.cos_out), 0);
        chk_eq("midrst sin", longint'(bus.sin_out), 0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        chk_eq("midrst no done", ndone, 0);
        run_op(32'h3C00_0000, "after rst 60deg", 1'b1);

        // sweep -128..+127 degrees in 1 degree steps
        for (int d = -128; d <= 127; d++) begin
            a = 32'(d) << 24;
            run_op(a, $sformatf("sweep %0d", d), 1'b1);
        end

        // random angles over the full range
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            run_op(a, $sformatf("rand %08h", a), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
